uart_rx_ctrl: RTL and testbench

Controller for the UART receiver. It owns the receiver's configuration (prescale, parity enable, parity type) and applies changes only at frame boundaries. It screens each completed frame for parity and stop errors and buffers good bytes in a small FIFO behind a valid/ready interface. It sits between the UART_RX instance and the system-side consumer, and keeps saturating error statistics.

---
 rtl/rx_ctrl_pkg.sv | 33 +++
 rtl/rx_sync_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the UART receiver controller: config FSM states,
// the receiver configuration word, legal prescale values and reset defaults.
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
    } rx_cfg_t;

    localparam logic [5:0] PRESCALE_4  = 6'd4;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic [5:0] PRESCALE_RST = PRESCALE_8;
    localparam logic       PAR_EN_RST   = 1'b0;
    localparam logic       PAR_TYP_RST  = 1'b0;

    localparam rx_cfg_t CFG_RST = '{prescale: PRESCALE_RST, par_en: PAR_EN_RST, par_typ: PAR_TYP_RST};

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_4) || (p == PRESCALE_8) ||
               (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word fall-through synchronous FIFO; head visible the cycle after the push.
// A push while full is accepted only if a pop happens in the same cycle.
module rx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Empty FIFO presents zero rather than a stale entry.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: frame-boundary config updates, frame screening into a FIFO,
// saturating error counters. Byte visible one cycle after data_valid; out_ready backpressure.
module uart_rx_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               cfg_prescale,
    input  logic                     cfg_par_en,
    input  logic                     cfg_par_typ,
    input  logic                     cfg_update,
    output logic                     cfg_reject,
    output logic                     cfg_pending,
    output logic [5:0]               prescale,
    output logic                     PAR_EN,
    output logic                     PAR_TYP,
    input  logic                     rx_busy,
    input  logic                     data_valid,
    input  logic                     par_err,
    input  logic                     stp_err,
    input  logic [7:0]               P_DATA,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         par_err_cnt,
    output logic [CNT_W-1:0]         stp_err_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    ctrl_state_e state, state_nxt;
    rx_cfg_t     shadow_q;
    rx_cfg_t     cfg_q;
    logic        req_legal;
    logic        shadow_ld;
    logic        cfg_apply;
    logic        reject_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        frame_good;
    logic        push;
    logic        ovf_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + 1'b1 : c;
    endfunction

    assign req_legal = cfg_update & prescale_legal(cfg_prescale);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // APPLY behaves like RUN for a fresh request; its copy uses the shadow as it stood
    // on entry, so a request landing in APPLY is applied on the following pass.
    always_comb begin
        state_nxt = state;
        shadow_ld = 1'b0;
        cfg_apply = 1'b0;
        case (state)
            RUN, APPLY: begin
                cfg_apply = (state == APPLY);
                state_nxt = RUN;
                if (req_legal) begin
                    shadow_ld = 1'b1;
                    state_nxt = rx_busy ? PEND : APPLY;
                end
            end
            PEND: begin
                shadow_ld = req_legal;
                if (!rx_busy) state_nxt = APPLY;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= CFG_RST;
            cfg_q    <= CFG_RST;
            reject_q <= 1'b0;
        end else begin
            if (shadow_ld) shadow_q <= '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
            if (cfg_apply) cfg_q <= shadow_q;
            reject_q <= cfg_update & ~prescale_legal(cfg_prescale);
        end
    end

    assign cfg_reject  = reject_q;
    assign cfg_pending = (state == PEND);
    assign prescale    = cfg_q.prescale;
    assign PAR_EN      = cfg_q.par_en;
    assign PAR_TYP     = cfg_q.par_typ;

    assign pop        = out_valid & out_ready;
    assign frame_good = ~par_err & ~stp_err;
    assign push       = data_valid & frame_good;
    assign ovf_inc    = push & fifo_full & ~pop;

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (P_DATA),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            par_err_cnt <= sat_inc(par_err_cnt, data_valid & par_err);
            stp_err_cnt <= sat_inc(stp_err_cnt, data_valid & stp_err);
            ovf_cnt     <= sat_inc(ovf_cnt, ovf_inc);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: inputs change 1 ns after a rising edge,
// outputs are compared at that same point, i.e. away from the active edge.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en, cfg_par_typ, cfg_update;
    logic       cfg_reject, cfg_pending;
    logic [5:0] prescale;
    logic       PAR_EN, PAR_TYP;
    logic       rx_busy, data_valid, par_err, stp_err;
    logic [7:0] P_DATA;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [2:0] fifo_level;
    logic [7:0] par_err_cnt, stp_err_cnt, ovf_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_update   (cfg_update),
        .cfg_reject   (cfg_reject),
        .cfg_pending  (cfg_pending),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .rx_busy      (rx_busy),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .P_DATA       (P_DATA),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .par_err_cnt  (par_err_cnt),
        .stp_err_cnt  (stp_err_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic pe, input logic se);
        data_valid = 1'b1;
        P_DATA     = d;
        par_err    = pe;
        stp_err    = se;
        step();
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_prescale = 6'd8; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_update = 1'b0;
        rx_busy = 1'b0; data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        P_DATA = 8'h00; out_ready = 1'b0;
        #1;
        step(); step();
        rst = 1'b0;

        // reset state
        check("rst_prescale", 32'(prescale), 32'd8);
        check("rst_par_en", 32'(PAR_EN), 32'd0);
        check("rst_par_typ", 32'(PAR_TYP), 32'd0);
        check("rst_pending", 32'(cfg_pending), 32'd0);
        check("rst_reject", 32'(cfg_reject), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_cnts", {8'd0, par_err_cnt, stp_err_cnt, ovf_cnt}, 32'd0);

        // three good frames streamed through with out_ready high
        out_ready = 1'b1;
        frame(8'hA5, 1'b0, 1'b0);
        check("stream0_valid", 32'(out_valid), 32'd1);
        check("stream0_data", 32'(out_data), 32'hA5);
        step();
        check("stream0_drained", 32'(out_valid), 32'd0);
        frame(8'h3C, 1'b0, 1'b0);
        check("stream1_data", 32'(out_data), 32'h3C);
        step();
        frame(8'h07, 1'b0, 1'b0);
        check("stream2_data", 32'(out_data), 32'h07);
        step();
        check("stream_cnts", {8'd0, par_err_cnt, stp_err_cnt, ovf_cnt}, 32'd0);

        // six frames into a stalled FIFO: four kept, two overflow
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_cnt", 32'(ovf_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 32'(out_data), 32'h10 + i);
            step();
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);

        // frame with both parity and stop errors is dropped
        frame(8'h07, 1'b1, 1'b1);
        check("err_not_pushed", 32'(out_valid), 32'd0);
        check("err_par_cnt", 32'(par_err_cnt), 32'd1);
        check("err_stp_cnt", 32'(stp_err_cnt), 32'd1);
        check("err_ovf_cnt", 32'(ovf_cnt), 32'd2);

        // config request during a frame waits for rx_busy to fall
        rx_busy = 1'b1;
        cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("pend_flag", 32'(cfg_pending), 32'd1);
        check("pend_prescale", 32'(prescale), 32'd8);
        step(); step();
        check("pend_hold_prescale", 32'(prescale), 32'd8);
        check("pend_hold_flag", 32'(cfg_pending), 32'd1);
        rx_busy = 1'b0;
        step();
        check("pend_clear", 32'(cfg_pending), 32'd0);
        check("pend_m1_prescale", 32'(prescale), 32'd8);
        step();
        check("apply_prescale", 32'(prescale), 32'd16);
        check("apply_par", {30'd0, PAR_EN, PAR_TYP}, 32'd3);

        // illegal prescale is rejected with a one-cycle pulse
        cfg_prescale = 6'd5; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("reject_pulse", 32'(cfg_reject), 32'd1);
        step();
        check("reject_end", 32'(cfg_reject), 32'd0);
        step();
        check("reject_prescale", 32'(prescale), 32'd16);
        check("reject_par", {30'd0, PAR_EN, PAR_TYP}, 32'd3);
        check("reject_pending", 32'(cfg_pending), 32'd0);

        // idle request applies two cycles later
        cfg_prescale = 6'd4; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("idle_n1_prescale", 32'(prescale), 32'd16);
        check("idle_no_reject", 32'(cfg_reject), 32'd0);
        step();
        check("idle_n2_prescale", 32'(prescale), 32'd4);
        check("idle_n2_par", {30'd0, PAR_EN, PAR_TYP}, 32'd1);

        // full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0);
        check("full_level", 32'(fifo_level), 32'd4);
        out_ready = 1'b1;
        frame(8'h24, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("pushpop_level", 32'(fifo_level), 32'd4);
        check("pushpop_ovf", 32'(ovf_cnt), 32'd2);
        check("pushpop_head", 32'(out_data), 32'h21);

        // reset in the middle of a burst
        data_valid = 1'b1; P_DATA = 8'h55; rst = 1'b1;
        step();
        data_valid = 1'b0; rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_prescale", 32'(prescale), 32'd8);
        check("midrst_cnts", {8'd0, par_err_cnt, stp_err_cnt, ovf_cnt}, 32'd0);

        // stop-error counter saturates at 255
        data_valid = 1'b1; stp_err = 1'b1; P_DATA = 8'hEE;
        for (int i = 0; i < 260; i++) step();
        data_valid = 1'b0; stp_err = 1'b0;
        step();
        check("sat_stp_cnt", 32'(stp_err_cnt), 32'd255);
        check("sat_par_cnt", 32'(par_err_cnt), 32'd0);
        check("sat_no_push", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
